// File: rtl/fp_writeback_ctrl.sv
// fp_writeback_ctrl
//   Writeback stage in front of the FP register file. It round-robin merges
//   results from three producers (0=load, 1=fpu, 2=div) onto the registered
//   frd/fdata_des/fdata_valid write port. It also keeps a per-register pending
//   scoreboard (busy_vec) that issue logic queries through chk_hazard.
//
//   Optional feature macro: FP_WB_BYPASS_EN
//     When defined, the write-port value is forwarded to readers through
//     fwd_hit1..3/fwd_data. A register being written this cycle then no longer
//     raises chk_hazard.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   issue_valid/_frd    FP-writing instruction issue (sets busy bit)
//   chk_frs1/2/3, frd   registers tested for RAW/WAW hazards
//   chk_hazard          any checked register pending (combinational)
//   {ld,fpu,div}_valid/_rd/_data/_ready  producer valid/ready result channels
//   frd, fdata_des, fdata_valid          registered register-file write port
//   busy_vec            scoreboard state (debug)
module fp_writeback_ctrl #(
  parameter int unsigned NSRC = 3,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_frd,
  input  logic [4:0]      chk_frs1,
  input  logic [4:0]      chk_frs2,
  input  logic [4:0]      chk_frs3,
  input  logic [4:0]      chk_frd,
  output logic            chk_hazard,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic            fpu_valid,
  input  logic [4:0]      fpu_rd,
  input  logic [XLEN-1:0] fpu_data,
  output logic            fpu_ready,
  input  logic            div_valid,
  input  logic [4:0]      div_rd,
  input  logic [XLEN-1:0] div_data,
  output logic            div_ready,
  output logic [4:0]      frd,
  output logic [XLEN-1:0] fdata_des,
  output logic            fdata_valid,
`ifdef FP_WB_BYPASS_EN
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic            fwd_hit3,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic [31:0]     busy_vec
);

  logic [NSRC-1:0] src_valid;
  logic [4:0]      src_rd   [NSRC];
  logic [XLEN-1:0] src_data [NSRC];

  assign src_valid   = {div_valid, fpu_valid, ld_valid};
  assign src_rd[0]   = ld_rd;
  assign src_rd[1]   = fpu_rd;
  assign src_rd[2]   = div_rd;
  assign src_data[0] = ld_data;
  assign src_data[1] = fpu_data;
  assign src_data[2] = div_data;

  logic [1:0]      rr_q, rr_d;
  logic [31:0]     busy_q, busy_d;
  logic [4:0]      frd_q, frd_d;
  logic [XLEN-1:0] fdata_q, fdata_d;
  logic            fvalid_q, fvalid_d;

  logic [NSRC-1:0] gnt;
  logic            gnt_any;
  logic [1:0]      gnt_idx;
  logic [1:0]      scan;

  // Scan rr, rr+1, rr+2 (mod 3); first valid wins. Reset suppresses all grants.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      scan = 2'((32'(rr_q) + k) % NSRC);
      if (!gnt_any && src_valid[scan] && rst) begin
        gnt_any   = 1'b1;
        gnt_idx   = scan;
        gnt[scan] = 1'b1;
      end
    end
  end

  assign ld_ready  = gnt[0];
  assign fpu_ready = gnt[1];
  assign div_ready = gnt[2];

  always_comb begin
    rr_d     = rr_q;
    frd_d    = frd_q;
    fdata_d  = fdata_q;
    fvalid_d = gnt_any;
    if (gnt_any) begin
      rr_d    = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      frd_d   = src_rd[gnt_idx];
      fdata_d = src_data[gnt_idx];
    end
  end

  // Clear for the write landing this edge first, so a same-edge re-issue wins.
  always_comb begin
    busy_d = busy_q;
    if (fvalid_q)    busy_d[frd_q]     = 1'b0;
    if (issue_valid) busy_d[issue_frd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q     <= '0;
      busy_q   <= '0;
      frd_q    <= '0;
      fdata_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      frd_q    <= frd_d;
      fdata_q  <= fdata_d;
      fvalid_q <= fvalid_d;
    end
  end

  logic [4:0] chk_reg [4];
  assign chk_reg[0] = chk_frs1;
  assign chk_reg[1] = chk_frs2;
  assign chk_reg[2] = chk_frs3;
  assign chk_reg[3] = chk_frd;

  always_comb begin
    chk_hazard = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef FP_WB_BYPASS_EN
      if (busy_q[chk_reg[k]] && !(fvalid_q && (frd_q == chk_reg[k])))
        chk_hazard = 1'b1;
`else
      if (busy_q[chk_reg[k]])
        chk_hazard = 1'b1;
`endif
    end
  end

`ifdef FP_WB_BYPASS_EN
  assign fwd_hit1 = fvalid_q && (frd_q == chk_frs1);
  assign fwd_hit2 = fvalid_q && (frd_q == chk_frs2);
  assign fwd_hit3 = fvalid_q && (frd_q == chk_frs3);
  assign fwd_data = fdata_q;
`endif

  assign frd         = frd_q;
  assign fdata_des   = fdata_q;
  assign fdata_valid = fvalid_q;
  assign busy_vec    = busy_q;

endmodule

// File: tb/tb_fp_writeback_ctrl.sv
// Self-checking bench for fp_writeback_ctrl: directed scenarios plus a
// randomized phase, checked against a reference arbiter/scoreboard model.
module tb_fp_writeback_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_frd;
  logic [4:0]  chk_frs1, chk_frs2, chk_frs3, chk_frd;
  logic        chk_hazard;
  logic        sv    [3];
  logic [4:0]  srd   [3];
  logic [31:0] sdata [3];
  logic        ld_valid, fpu_valid, div_valid;
  logic [4:0]  ld_rd, fpu_rd, div_rd;
  logic [31:0] ld_data, fpu_data, div_data;
  logic        ld_ready, fpu_ready, div_ready;
  logic [4:0]  frd;
  logic [31:0] fdata_des;
  logic        fdata_valid;
  logic [31:0] busy_vec;
`ifdef FP_WB_BYPASS_EN
  logic        fwd_hit1, fwd_hit2, fwd_hit3;
  logic [31:0] fwd_data;
`endif

  assign ld_valid  = sv[0];
  assign fpu_valid = sv[1];
  assign div_valid = sv[2];
  assign ld_rd     = srd[0];
  assign fpu_rd    = srd[1];
  assign div_rd    = srd[2];
  assign ld_data   = sdata[0];
  assign fpu_data  = sdata[1];
  assign div_data  = sdata[2];

  fp_writeback_ctrl #(.NSRC(3), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_frd(issue_frd),
    .chk_frs1(chk_frs1), .chk_frs2(chk_frs2), .chk_frs3(chk_frs3), .chk_frd(chk_frd),
    .chk_hazard(chk_hazard),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
    .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data), .div_ready(div_ready),
    .frd(frd), .fdata_des(fdata_des), .fdata_valid(fdata_valid),
`ifdef FP_WB_BYPASS_EN
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_hit3(fwd_hit3), .fwd_data(fwd_data),
`endif
    .busy_vec(busy_vec)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  function automatic int pick(input logic [1:0] rr, input logic [2:0] v);
    for (int k = 0; k < 3; k++) begin
      int s = (int'(rr) + k) % 3;
      if (v[s] === 1'b1) return s;
    end
    return -1;
  endfunction

  function automatic logic [31:0] busy_next(input logic [31:0] b, input logic fv,
                                            input logic [4:0] wr, input logic iv,
                                            input logic [4:0] ir);
    logic [31:0] nb = b;
    if (fv) nb[wr] = 1'b0;
    if (iv) nb[ir] = 1'b1;
    return nb;
  endfunction

  function automatic logic haz(input logic [31:0] b, input logic fv, input logic [4:0] wr,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] r3);
    logic [4:0] r [4];
    logic h = 1'b0;
    r = '{r0, r1, r2, r3};
    for (int k = 0; k < 4; k++) begin
`ifdef FP_WB_BYPASS_EN
      if (b[r[k]] && !(fv && wr == r[k])) h = 1'b1;
`else
      if (b[r[k]]) h = 1'b1;
`endif
    end
    return h;
  endfunction

  logic [1:0]  m_rr    = '0;
  logic [31:0] m_busy  = '0;
  logic        m_fv    = 1'b0;
  logic [4:0]  m_frd   = '0;
  logic [31:0] m_fdata = '0;
  int          m_gnt   = -1;
  bit          m_init  = 1'b0;
  logic [2:0]  vvec;
  int          m_pick;

  assign vvec   = {sv[2], sv[1], sv[0]};
  assign m_pick = pick(m_rr, vvec);

  always @(posedge clk) begin
    m_init <= 1'b1;
    if (!rst) begin
      m_rr    <= '0;
      m_busy  <= '0;
      m_fv    <= 1'b0;
      m_frd   <= '0;
      m_fdata <= '0;
      m_gnt   <= -1;
      exp_q.delete();
    end else begin
      m_gnt  <= m_pick;
      m_busy <= busy_next(m_busy, m_fv, m_frd, issue_valid, issue_frd);
      if (m_pick >= 0) begin
        exp_q.push_back({srd[m_pick], sdata[m_pick]});
        m_rr    <= (m_pick == 2) ? 2'd0 : 2'(m_pick + 1);
        m_fv    <= 1'b1;
        m_frd   <= srd[m_pick];
        m_fdata <= sdata[m_pick];
      end else begin
        m_fv <= 1'b0;
      end
    end
  end

  // Continuous checks, sampled mid-cycle
  always @(negedge clk) begin
    if (m_init) begin
      check_eq("busy_vec", busy_vec, m_busy);
      check_eq("ld_ready", ld_ready, rst && m_pick == 0);
      check_eq("fpu_ready", fpu_ready, rst && m_pick == 1);
      check_eq("div_ready", div_ready, rst && m_pick == 2);
      check_eq("chk_hazard", chk_hazard,
               haz(m_busy, m_fv, m_frd, chk_frs1, chk_frs2, chk_frs3, chk_frd));
      if (exp_q.size() > 0) begin
        check_eq("wr_valid", fdata_valid, 1'b1);
        check_eq("wr_frd", frd, exp_q[0].rd);
        check_eq("wr_data", fdata_des, exp_q[0].data);
        void'(exp_q.pop_front());
      end else begin
        check_eq("idle_valid", fdata_valid, 1'b0);
        check_eq("idle_frd", frd, m_frd);
        check_eq("idle_data", fdata_des, m_fdata);
      end
`ifdef FP_WB_BYPASS_EN
      check_eq("fwd_hit1", fwd_hit1, m_fv && m_frd == chk_frs1);
      check_eq("fwd_hit2", fwd_hit2, m_fv && m_frd == chk_frs2);
      check_eq("fwd_hit3", fwd_hit3, m_fv && m_frd == chk_frs3);
      check_eq("fwd_data", fwd_data, m_fdata);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rd_seq [4] = '{5'd1, 5'd2, 5'd3, 5'd1};

  initial begin
    rst = 1'b0; issue_valid = 1'b0; issue_frd = '0;
    chk_frs1 = '0; chk_frs2 = '0; chk_frs3 = '0; chk_frd = '0;
    for (int s = 0; s < 3; s++) begin sv[s] = 1'b0; srd[s] = '0; sdata[s] = '0; end
    cyc(); cyc();
    check_eq("rst_frd", frd, 0);
    check_eq("rst_data", fdata_des, 0);
    check_eq("rst_valid", fdata_valid, 0);
    check_eq("rst_busy", busy_vec, 0);
    rst = 1'b1;

    // issue to f5 sets busy bit, visible next cycle
    issue_valid = 1'b1; issue_frd = 5'd5;
    cyc();
    issue_valid = 1'b0; chk_frs1 = 5'd5;
    #1;
    check_eq("issue_busy", busy_vec, 32'h0000_0020);
    check_eq("issue_haz", chk_hazard, 1'b1);

    // fpu result for f5: same-cycle ready, one-cycle write, then busy clears
    sv[1] = 1'b1; srd[1] = 5'd5; sdata[1] = 32'h3F80_0000;
    #1;
    check_eq("fpu_ready_now", fpu_ready, 1'b1);
    cyc();
    sv[1] = 1'b0;
    #1;
    check_eq("fpu_wr_frd", frd, 5);
    check_eq("fpu_wr_data", fdata_des, 32'h3F80_0000);
    check_eq("fpu_wr_valid", fdata_valid, 1'b1);
    cyc();
    #1;
    check_eq("clr_busy", busy_vec, 32'h0);
    check_eq("clr_valid", fdata_valid, 1'b0);
    check_eq("clr_haz", chk_hazard, 1'b0);

    // all three sources held valid after reset: load, fpu, div, load
    rst = 1'b0; cyc(); rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sv[s] = 1'b1; srd[s] = 5'(s + 1); sdata[s] = 32'hA0 + 32'(s);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      #1;
      check_eq($sformatf("rr_frd%0d", k), frd, rd_seq[k]);
    end
    for (int s = 0; s < 3; s++) sv[s] = 1'b0;
    cyc();

    // write and re-issue of f9 on the same edge: busy stays set
    issue_valid = 1'b1; issue_frd = 5'd9;
    cyc();
    issue_valid = 1'b0; sv[1] = 1'b1; srd[1] = 5'd9; sdata[1] = 32'hCAFE_0009;
    cyc();
    sv[1] = 1'b0; chk_frs2 = 5'd9;
    #1;
    check_eq("f9_wr_valid", fdata_valid, 1'b1);
    check_eq("f9_wr_frd", frd, 9);
`ifdef FP_WB_BYPASS_EN
    check_eq("byp_hit2", fwd_hit2, 1'b1);
    check_eq("byp_hit1", fwd_hit1, 1'b0);
    check_eq("byp_data", fwd_data, 32'hCAFE_0009);
    check_eq("byp_haz", chk_hazard, 1'b0);
`else
    check_eq("nobyp_haz", chk_hazard, 1'b1);
`endif
    issue_valid = 1'b1; issue_frd = 5'd9;
    cyc();
    issue_valid = 1'b0;
    #1;
    check_eq("set_wins", busy_vec, 32'h0000_0200);

    // reset mid-operation
    issue_valid = 1'b1;
    issue_frd = 5'd8;  cyc();
    issue_frd = 5'd10; cyc();
    issue_frd = 5'd11; cyc();
    issue_valid = 1'b0;
    #1;
    check_eq("busy_f00", busy_vec, 32'h0000_0F00);
    sv[2] = 1'b1; srd[2] = 5'd12; sdata[2] = 32'h1234_5678; rst = 1'b0;
    #1;
    check_eq("rst_div_ready", div_ready, 1'b0);
    cyc();
    #1;
    check_eq("midrst_busy", busy_vec, 32'h0);
    check_eq("midrst_valid", fdata_valid, 1'b0);
    check_eq("midrst_div_ready", div_ready, 1'b0);
    rst = 1'b1;
    cyc();
    sv[2] = 1'b0;
    chk_frs1 = '0; chk_frs2 = '0;

    // randomized traffic: producers hold until accepted
    for (int n = 0; n < 400; n++) begin
      cyc();
      for (int s = 0; s < 3; s++) begin
        if (!sv[s] || m_gnt == s) begin
          sv[s]    = 1'($urandom_range(0, 1));
          srd[s]   = 5'($urandom_range(0, 7));
          sdata[s] = $urandom;
        end
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_frd   = 5'($urandom_range(0, 7));
      chk_frs1    = 5'($urandom_range(0, 7));
      chk_frs2    = 5'($urandom_range(0, 7));
      chk_frs3    = 5'($urandom_range(0, 7));
      chk_frd     = 5'($urandom_range(0, 7));
      rst         = ($urandom_range(0, 99) != 0);
    end
    rst = 1'b1; issue_valid = 1'b0;
    for (int s = 0; s < 3; s++) sv[s] = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_writeback_ctrl.md
Name: fp_writeback_ctrl

Overview:
- Writeback stage sitting directly upstream of the floating-point register file. It drives that file's `frd` / `fdata_des` / `fdata_valid` write port.
- Round-robin arbitration merges results from three producers: the FLW load path, the pipelined FPU, and the iterative FDIV/FSQRT unit.
- It also keeps a per-register pending scoreboard so that issue logic can stall on RAW and WAW hazards against in-flight FP results.

Parameters:
- NSRC, 3, number of result sources. Fixed at 3; only index order matters: 0=load, 1=fpu, 2=div.
- XLEN, 32, result data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low; clock clk
- issue_valid  in  1  an FP-writing instruction issues this cycle
- issue_frd  in  5  destination register of the issuing instruction
- chk_frs1  in  5  source register 1 to test for hazards
- chk_frs2  in  5  source register 2 to test for hazards
- chk_frs3  in  5  source register 3 to test for hazards
- chk_frd  in  5  destination register to test for hazards
- chk_hazard  out  1  combinational: any checked register is pending
- ld_valid  in  1  load result valid
- ld_rd  in  5  load result destination
- ld_data  in  32  load result data
- ld_ready  out  1  load result accepted this cycle
- fpu_valid  in  1  FPU result valid
- fpu_rd  in  5  FPU result destination
- fpu_data  in  32  FPU result data
- fpu_ready  out  1  FPU result accepted this cycle
- div_valid  in  1  divider result valid
- div_rd  in  5  divider result destination
- div_data  in  32  divider result data
- div_ready  out  1  divider result accepted this cycle
- frd  out  5  register-file write address, registered
- fdata_des  out  32  register-file write data, registered
- fdata_valid  out  1  register-file write enable, registered
- busy_vec  out  32  scoreboard state, for debug

Behaviour:
- Reset (rst==0 at posedge):
  - busy_vec=0, fdata_valid=0, frd=0, fdata_des=0.
  - Round-robin pointer rr=0, so load has top priority.
  - All *_ready are forced to 0 while rst==0.
- Arbitration (combinational):
  - Candidates are scanned starting at index rr, wrapping (rr, rr+1, rr+2 mod 3).
  - The first source with valid=1 is granted, and its ready=1. All other readies are 0.
  - At most one ready is high per cycle.
  - A source must hold valid/rd/data stable until it sees ready. Accept = valid & ready at posedge.
- Pointer update: on a grant to source g, rr <= (g+1) mod 3. With no grant, rr holds.
- Output register:
  - On a grant, at the next posedge: frd<=rd_g, fdata_des<=data_g, fdata_valid<=1.
  - With no grant: fdata_valid<=0. frd and fdata_des hold their values.
  - Latency: exactly 1 cycle from accept to write-port assertion.
  - The register file never backpressures, so throughput is 1 result/cycle.
- Scoreboard:
  - On issue_valid, busy[issue_frd] is set at posedge.
  - When fdata_valid==1, busy[frd] is cleared at posedge. The write lands in the register file on that same edge.
  - Same edge, same register, set and clear both active: set wins, because a new producer is in flight.
  - issue_valid to an already-busy register: the bit stays 1. Upstream must not create this WAW; chk_hazard exists to prevent it.
  - All 32 registers f0–f31 are tracked. f0 is not hardwired in F.
- chk_hazard = busy[chk_frs1] | busy[chk_frs2] | busy[chk_frs3] | busy[chk_frd].
  - It reflects the current registered busy state.
  - issue_valid in the same cycle is not visible until the next cycle.
- Reset mid-operation: all pending results are dropped and the scoreboard is cleared. Producers must be reset by the same rst.

Optional Feature:
- Macro FP_WB_BYPASS_EN.
- With the macro defined:
  - Added outputs fwd_hit1, fwd_hit2, fwd_hit3 (1 bit each), set when fdata_valid & (frd==chk_frsN).
  - Added output fwd_data (32 bits), equal to fdata_des.
  - chk_hazard ignores a checked register equal to frd while fdata_valid==1, since that value is forwarded this cycle.
- Without the macro: these ports are absent, and chk_hazard stays set until the register-file write completes.

Test Plan:
- Reset, then issue_valid=1, issue_frd=5 -> next cycle busy_vec=0x00000020; chk_frs1=5 gives chk_hazard=1.
- fpu_valid=1, fpu_rd=5, fpu_data=0x3F800000 -> fpu_ready=1 the same cycle. Next cycle frd=5, fdata_des=0x3F800000, fdata_valid=1. The following cycle busy[5]=0 and fdata_valid=0.
- ld, fpu and div all valid and held, with rd=1/2/3, after reset -> grants in order load, fpu, div, load over 4 cycles. frd sequence is 1, 2, 3, 1.
- busy[7]=1, fdata_valid=1 with frd=7, and issue_valid with issue_frd=7 on the same edge -> busy[7] stays 1.
- rst=0 asserted while div_valid=1 and busy_vec=0x00000F00 -> next cycle busy_vec=0, fdata_valid=0, div_ready=0 during reset.
- FP_WB_BYPASS_EN: fdata_valid=1, frd=9, chk_frs2=9 -> fwd_hit2=1, fwd_data=fdata_des, chk_hazard=0. Without the macro, chk_hazard=1.
